// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg
// Shared constants for the register command sequencer: opcode values,
// FSM state encodings and default widths. Also holds a small helper that
// tells the sequencer which opcodes honour the repeat count.
package reg_seq_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int CNT_W_DEF  = 2;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_CLR  = 4'd1;
   localparam logic [3:0] OP_LOAD = 4'd2;
   localparam logic [3:0] OP_INC  = 4'd3;
   localparam logic [3:0] OP_DEC  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_ROR  = 4'd7;
   localparam logic [3:0] OP_ROL  = 4'd8;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EXEC = 1'b1;

   // Only the counting/shifting ops expand into a burst; everything else
   // (including the undefined codes) is a single cycle.
   function automatic logic is_repeated(input logic [3:0] op);
      return (op >= OP_INC) && (op <= OP_ROL);
   endfunction

endpackage

// File: rtl/reg_seq_decode.sv
// reg_seq_decode
// Purely combinational control decode for the register sequencer.
// Ports:
//   state  - current sequencer state (controls only active in S_EXEC)
//   op     - latched opcode
//   data   - latched command data (load value / fill bit in bit 0)
//   reg_q  - live register output, used as rotate feedback
//   cl, ld, inc, dec, sr, ir, sl, il - register control lines
//   reg_d  - register data input (load value during LOAD, else 0)
module reg_seq_decode
   import reg_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [0:0]        state,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] reg_q,
   output logic              cl,
   output logic              ld,
   output logic              inc,
   output logic              dec,
   output logic              sr,
   output logic              ir,
   output logic              sl,
   output logic              il,
   output logic [DATA_W-1:0] reg_d
);

   // Everything defaults low so IDLE, NOP and the undefined opcodes drive
   // nothing. Rotates take their feedback bit from the live register
   // output each cycle, so every pulse of a burst rotates the current value.
   always_comb begin
      cl    = 1'b0;
      ld    = 1'b0;
      inc   = 1'b0;
      dec   = 1'b0;
      sr    = 1'b0;
      ir    = 1'b0;
      sl    = 1'b0;
      il    = 1'b0;
      reg_d = '0;
      if (state == S_EXEC) begin
         case (op)
            OP_CLR:  cl = 1'b1;
            OP_LOAD: begin
               ld    = 1'b1;
               reg_d = data;
            end
            OP_INC:  inc = 1'b1;
            OP_DEC:  dec = 1'b1;
            OP_SHR: begin
               sr = 1'b1;
               ir = data[0];
            end
            OP_SHL: begin
               sl = 1'b1;
               il = data[0];
            end
            OP_ROR: begin
               sr = 1'b1;
               ir = reg_q[0];
            end
            OP_ROL: begin
               sl = 1'b1;
               il = reg_q[DATA_W-1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/reg_sequencer.sv
// reg_sequencer
// Accepts one opcode per valid/ready handshake and expands it into a burst
// of single-cycle control pulses for the downstream 4-bit register.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   cmd_valid/ready  - command handshake (ready only while idle)
//   cmd_op           - opcode, cmd_data - load value / fill bit,
//   cmd_cnt          - repeat count minus one
//   reg_q            - register output (rotate feedback)
//   cl..il, reg_d    - register controls and data input
//   busy             - burst in progress, done - pulse on last burst cycle
module reg_sequencer
   import reg_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [CNT_W-1:0]  cmd_cnt,
   input  logic [DATA_W-1:0] reg_q,
   output logic              cl,
   output logic              ld,
   output logic              inc,
   output logic              dec,
   output logic              sr,
   output logic              ir,
   output logic              sl,
   output logic              il,
   output logic [DATA_W-1:0] reg_d,
   output logic              busy,
   output logic              done
);

   logic [0:0]        state;
   logic [3:0]        op;
   logic [DATA_W-1:0] data;
   logic [CNT_W-1:0]  remaining;
   logic              accept;

   // Ready is held low during reset so nothing is accepted on a reset edge.
   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state == S_EXEC);
   assign done      = busy && (remaining == '0);

   // FSM plus command latches. The burst length is held as "pulses left
   // after this one", so the last cycle is simply remaining == 0 and the
   // FSM drops back to IDLE on that edge, giving one idle cycle between
   // back-to-back commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op        <= OP_NOP;
         data      <= '0;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state     <= S_EXEC;
                  op        <= cmd_op;
                  data      <= cmd_data;
                  remaining <= is_repeated(cmd_op) ? cmd_cnt : '0;
               end
            end
            S_EXEC: begin
               if (remaining == '0) begin
                  state <= S_IDLE;
               end else begin
                  remaining <= remaining - CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Control decode lives in its own block so the FSM stays readable.
   reg_seq_decode #(
      .DATA_W (DATA_W)
   ) u_decode (
      .state (state),
      .op    (op),
      .data  (data),
      .reg_q (reg_q),
      .cl    (cl),
      .ld    (ld),
      .inc   (inc),
      .dec   (dec),
      .sr    (sr),
      .ir    (ir),
      .sl    (sl),
      .il    (il),
      .reg_d (reg_d)
   );

endmodule

// File: tb/tb_reg_sequencer.sv
// tb_reg_sequencer
// Scoreboard bench for reg_sequencer. A behavioural 4-bit register sits
// downstream of the DUT. On each accepted command the bench predicts every
// cycle of the burst (controls, done, register value) and queues it; each
// falling edge pops one expected cycle, or expects an idle cycle when the
// queue is empty.
module tb_reg_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [3:0] cmd_data;
   logic [1:0] cmd_cnt;
   logic [3:0] reg_q;
   logic       cl, ld, inc, dec, sr, ir, sl, il;
   logic [3:0] reg_d;
   logic       busy;
   logic       done;

   typedef struct packed {
      logic [14:0] outs;
      logic [3:0]  q;
      logic [3:0]  q_next;
   } rec_t;

   rec_t        sb[$];
   rec_t        rec;
   int          total = 0;
   int          bad = 0;
   int          accept_count = 0;
   logic [3:0]  reg_model = 4'h0;
   logic [3:0]  pred_q = 4'h0;
   logic [3:0]  sim_q;
   logic [7:0]  ctl;
   logic [14:0] dut_vec;
   logic [14:0] exp_vec;
   int          burst_n;

   reg_sequencer #(
      .DATA_W (4),
      .CNT_W  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_cnt   (cmd_cnt),
      .reg_q     (reg_q),
      .cl        (cl),
      .ld        (ld),
      .inc       (inc),
      .dec       (dec),
      .sr        (sr),
      .ir        (ir),
      .sl        (sl),
      .il        (il),
      .reg_d     (reg_d),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the expected one and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected register controls {cl,ld,inc,dec,sr,ir,sl,il} for one burst
   // cycle of an opcode, given the register value during that cycle.
   function automatic logic [7:0] expCtl(input logic [3:0] op, input logic [3:0] d, input logic [3:0] q);
      case (op)
         4'd1:    return 8'b1000_0000;
         4'd2:    return 8'b0100_0000;
         4'd3:    return 8'b0010_0000;
         4'd4:    return 8'b0001_0000;
         4'd5:    return {4'b0000, 1'b1, d[0], 2'b00};
         4'd6:    return {6'b000000, 1'b1, d[0]};
         4'd7:    return {4'b0000, 1'b1, q[0], 2'b00};
         4'd8:    return {6'b000000, 1'b1, q[3]};
         default: return 8'h00;
      endcase
   endfunction

   // Behaviour of the downstream register for one clock edge.
   function automatic logic [3:0] regStep(input logic [3:0] q, input logic [7:0] c, input logic [3:0] d);
      if (c[7])      return 4'h0;
      else if (c[6]) return d;
      else if (c[5]) return q + 4'h1;
      else if (c[4]) return q - 4'h1;
      else if (c[3]) return {c[2], q[3:1]};
      else if (c[1]) return {q[2:0], c[0]};
      else           return q;
   endfunction

   // The register itself, driven by the DUT controls.
   always @(posedge clk) begin
      reg_model <= regStep(reg_model, {cl, ld, inc, dec, sr, ir, sl, il}, reg_d);
   end
   assign reg_q = reg_model;

   // Per-cycle check and scoreboard fill. Inputs are driven shortly after
   // the rising edge, so at the falling edge they are what the next edge
   // will sample. A command is accepted only when this cycle is idle.
   always @(negedge clk) begin
      dut_vec = {busy, done, cmd_ready, cl, ld, inc, dec, sr, ir, sl, il, reg_d};
      if (sb.size() > 0) begin
         rec = sb.pop_front();
         checkOutput("burst_outputs", {17'd0, dut_vec}, {17'd0, rec.outs});
         checkOutput("burst_reg", {28'd0, reg_model}, {28'd0, rec.q});
         pred_q = rec.q_next;
      end else begin
         exp_vec = {2'b00, ~rst, 12'd0};
         checkOutput("idle_outputs", {17'd0, dut_vec}, {17'd0, exp_vec});
         checkOutput("idle_reg", {28'd0, reg_model}, {28'd0, pred_q});
         if (cmd_valid && !rst) begin
            accept_count++;
            burst_n = ((cmd_op >= 4'd3) && (cmd_op <= 4'd8)) ? int'(cmd_cnt) + 1 : 1;
            sim_q = reg_model;
            for (int i = 0; i < burst_n; i++) begin
               ctl = expCtl(cmd_op, cmd_data, sim_q);
               rec.outs   = {1'b1, (i == burst_n - 1), 1'b0, ctl,
                             (cmd_op == 4'd2) ? cmd_data : 4'h0};
               rec.q      = sim_q;
               rec.q_next = regStep(sim_q, ctl, cmd_data);
               sim_q      = rec.q_next;
               sb.push_back(rec);
            end
         end
      end
      if (rst) sb.delete();
   end

   // Present one command and hold it until the scoreboard sees it accepted.
   task automatic applyStimulus(input logic [3:0] op, input logic [3:0] d, input logic [1:0] c);
      int start;
      bit ok;
      start = accept_count;
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_cnt   = c;
      for (int k = 0; k < 30 && !ok; k++) begin
         @(posedge clk);
         #2;
         if (accept_count != start) ok = 1'b1;
      end
      if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_data  = 4'd0;
      cmd_cnt   = 2'd0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      $display("[TB] reset released");

      applyStimulus(4'd2, 4'hA, 2'd0);
      idleCycles(3);

      applyStimulus(4'd2, 4'hE, 2'd0);
      idleCycles(1);
      applyStimulus(4'd3, 4'h0, 2'd3);
      idleCycles(5);

      applyStimulus(4'd2, 4'h9, 2'd0);
      idleCycles(1);
      applyStimulus(4'd8, 4'h0, 2'd1);
      idleCycles(3);

      applyStimulus(4'd1, 4'h0, 2'd0);
      idleCycles(1);
      applyStimulus(4'd5, 4'h1, 2'd2);
      idleCycles(4);

      applyStimulus(4'd4, 4'h0, 2'd3);
      applyStimulus(4'd12, 4'hF, 2'd3);
      idleCycles(3);

      applyStimulus(4'd7, 4'h0, 2'd3);
      applyStimulus(4'd6, 4'h0, 2'd2);
      idleCycles(5);

      applyStimulus(4'd3, 4'h0, 2'd3);
      idleCycles(1);
      rst = 1'b1;
      idleCycles(1);
      rst = 1'b0;
      idleCycles(3);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
      end

      for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() > 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      idleCycles(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
